// File: rtl/hcsr04_sensor_emulator_pkg.sv
// -----------------------------------------------------------------------------
// hcsr04_sensor_emulator_pkg
// Shared definitions for the HC-SR04 sensor emulator: FSM state encodings
// (which double as the db_estado debug codes), the illegal-state debug code,
// default timing constants for a 50 MHz clock, and small elaboration helpers
// used to size the counters.
// No ports.
// -----------------------------------------------------------------------------
package hcsr04_sensor_emulator_pkg;

    // Encodings are chosen equal to the db_estado codes so the debug output is a
    // plain copy of the state register for every legal state.
    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0000,
        ST_TRIG    = 4'b0001,
        ST_BURST   = 4'b0010,
        ST_ECHO    = 4'b0011,
        ST_HOLDOFF = 4'b0100
    } estado_t;

    localparam logic [3:0] DB_ILEGAL = 4'b1110;

    localparam int DEF_CICLOS_POR_CM   = 2941;
    localparam int DEF_TRIG_MIN_CICLOS = 500;
    localparam int DEF_BURST_CICLOS    = 10000;
    localparam int DEF_DIST_MAX        = 400;
    localparam int DEF_TIMEOUT_CICLOS  = 1900000;
    localparam int DEF_HOLDOFF_CICLOS  = 3000000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Register width able to hold 0..m-1 (at least one bit).
    function automatic int largura(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/hcsr04_sensor_emulator_contador.sv
// -----------------------------------------------------------------------------
// hcsr04_sensor_emulator_contador
// Generic modulo-M up counter. Counts 0..M-1 and wraps to 0 when advanced
// from M-1. Clear has priority over count.
// Ports:
//   clock  in   system clock
//   reset  in   synchronous active-high reset (q -> 0)
//   zera   in   synchronous clear (q -> 0)
//   conta  in   advance by one
//   q      out  current count, width $clog2(M) (min 1)
//   fim    out  high while q == M-1
// -----------------------------------------------------------------------------
module hcsr04_sensor_emulator_contador
    import hcsr04_sensor_emulator_pkg::*;
#(
    parameter  int M = 2,
    localparam int W = largura(M)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera,
    input  logic         conta,
    output logic [W-1:0] q,
    output logic         fim
);

    localparam logic [W-1:0] ULTIMO = W'(M - 1);

    always_ff @(posedge clock) begin
        if (reset || zera) begin
            q <= '0;
        end else if (conta) begin
            q <= (q == ULTIMO) ? '0 : q + W'(1);
        end
    end

    assign fim = (q == ULTIMO);

endmodule

// File: rtl/hcsr04_sensor_emulator.sv
// -----------------------------------------------------------------------------
// hcsr04_sensor_emulator
// Behavioural responder for the HC-SR04 ultrasonic sensor. A trigger pulse of
// at least TRIG_MIN_CICLOS synchronized cycles is accepted on its falling edge;
// after BURST_CICLOS cycles an echo pulse of distance*CICLOS_POR_CM cycles is
// produced (TIMEOUT_CICLOS when the distance is 0 or above DIST_MAX).
//
// Build option: define HCSR04_EMU_HOLDOFF_EN to add a HOLDOFF_CICLOS trigger
// lockout after each echo (ocupado stays high through it).
//
// Ports:
//   clock      in   system clock
//   reset      in   synchronous active-high reset
//   trigger    in   trigger from the interface controller (asynchronous)
//   distancia  in   simulated distance in cm, sampled at trigger acceptance
//   echo       out  echo pulse, registered
//   ocupado    out  busy from trigger acceptance to end of echo (or holdoff)
//   db_estado  out  debug state code
//
// state    | meaning
// ---------+----------------------------------------------------------------
// IDLE     | waiting for synchronized trigger high
// TRIG     | measuring trigger width (saturating); accept/reject on fall
// BURST    | fixed delay standing in for the 8-cycle 40 kHz burst
// ECHO     | echo high; sub-count mod CICLOS_POR_CM plus cm count vs distance
// HOLDOFF  | post-echo trigger lockout (only with HCSR04_EMU_HOLDOFF_EN)
// -----------------------------------------------------------------------------
module hcsr04_sensor_emulator
    import hcsr04_sensor_emulator_pkg::*;
#(
    parameter int CICLOS_POR_CM   = DEF_CICLOS_POR_CM,
    parameter int TRIG_MIN_CICLOS = DEF_TRIG_MIN_CICLOS,
    parameter int BURST_CICLOS    = DEF_BURST_CICLOS,
    parameter int DIST_MAX        = DEF_DIST_MAX,
    parameter int TIMEOUT_CICLOS  = DEF_TIMEOUT_CICLOS,
    parameter int HOLDOFF_CICLOS  = DEF_HOLDOFF_CICLOS
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       trigger,
    input  logic [8:0] distancia,
    output logic       echo,
    output logic       ocupado,
    output logic [3:0] db_estado
);

    // One sub-counter serves both the burst delay and the echo timing, so it is
    // sized for the largest terminal count it has to reach.
    localparam int SUB_M  = max3(BURST_CICLOS, CICLOS_POR_CM, TIMEOUT_CICLOS);
    localparam int SUB_W  = largura(SUB_M);
    localparam int CM_M   = DIST_MAX;
    localparam int CM_W   = largura(CM_M);
    localparam int TRIG_M = TRIG_MIN_CICLOS + 1;

    localparam logic [SUB_W-1:0] SUB_FIM_BURST   = SUB_W'(BURST_CICLOS - 1);
    localparam logic [SUB_W-1:0] SUB_FIM_CM      = SUB_W'(CICLOS_POR_CM - 1);
    localparam logic [SUB_W-1:0] SUB_FIM_TIMEOUT = SUB_W'(TIMEOUT_CICLOS - 1);

`ifdef HCSR04_EMU_HOLDOFF_EN
    localparam estado_t ST_POS_ECHO = ST_HOLDOFF;
`else
    localparam estado_t ST_POS_ECHO = ST_IDLE;
    localparam int      HOLDOFF_UNUSED = HOLDOFF_CICLOS;
`endif

    estado_t state, next;

    logic       trig_m, trig_s;
    logic [8:0] dist_q;
    logic       in_range_q;
    logic       dist_ok;
    logic       aceita;
    logic       fim_echo;
    logic       cm_ultimo;

    logic             trig_zera, trig_conta, trig_fim;
    logic [largura(TRIG_M)-1:0] trig_q_unused;
    logic             sub_zera, sub_conta, sub_fim_unused;
    logic [SUB_W-1:0] sub_q;
    logic             cm_zera, cm_conta, cm_fim_unused;
    logic [CM_W-1:0]  cm_q;

    // Trigger width saturates at TRIG_MIN_CICLOS: counting stops once fim is
    // reached, so fim alone means "long enough".
    hcsr04_sensor_emulator_contador #(.M(TRIG_M)) u_trig (
        .clock (clock),
        .reset (reset),
        .zera  (trig_zera),
        .conta (trig_conta),
        .q     (trig_q_unused),
        .fim   (trig_fim)
    );

    hcsr04_sensor_emulator_contador #(.M(SUB_M)) u_sub (
        .clock (clock),
        .reset (reset),
        .zera  (sub_zera),
        .conta (sub_conta),
        .q     (sub_q),
        .fim   (sub_fim_unused)
    );

    hcsr04_sensor_emulator_contador #(.M(CM_M)) u_cm (
        .clock (clock),
        .reset (reset),
        .zera  (cm_zera),
        .conta (cm_conta),
        .q     (cm_q),
        .fim   (cm_fim_unused)
    );

`ifdef HCSR04_EMU_HOLDOFF_EN
    logic hold_zera, hold_conta, hold_fim;
    logic [largura(HOLDOFF_CICLOS)-1:0] hold_q_unused;

    assign hold_zera = (state != ST_HOLDOFF);

    hcsr04_sensor_emulator_contador #(.M(HOLDOFF_CICLOS)) u_hold (
        .clock (clock),
        .reset (reset),
        .zera  (hold_zera),
        .conta (hold_conta),
        .q     (hold_q_unused),
        .fim   (hold_fim)
    );
`endif

    assign dist_ok   = (distancia != 9'd0) && (int'(distancia) <= DIST_MAX);
    // The last cm is the one numbered d-1 (cm count starts at 0).
    assign cm_ultimo = ((int'(cm_q) + 1) == int'(dist_q));

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            trig_m     <= 1'b0;
            trig_s     <= 1'b0;
            echo       <= 1'b0;
            ocupado    <= 1'b0;
            dist_q     <= '0;
            in_range_q <= 1'b0;
        end else begin
            trig_m  <= trigger;
            trig_s  <= trig_m;
            echo    <= (next == ST_ECHO);
            ocupado <= (next == ST_BURST) || (next == ST_ECHO) || (next == ST_HOLDOFF);
            if (aceita) begin
                dist_q     <= distancia;
                in_range_q <= dist_ok;
            end
        end
    end

    always_comb begin
        next       = state;
        aceita     = 1'b0;
        fim_echo   = 1'b0;
        trig_zera  = 1'b0;
        trig_conta = 1'b0;
        sub_zera   = 1'b0;
        sub_conta  = 1'b0;
        cm_zera    = 1'b0;
        cm_conta   = 1'b0;
`ifdef HCSR04_EMU_HOLDOFF_EN
        hold_conta = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                sub_zera = 1'b1;
                cm_zera  = 1'b1;
                if (trig_s) begin
                    trig_conta = 1'b1;
                    next       = ST_TRIG;
                end else begin
                    trig_zera = 1'b1;
                end
            end
            ST_TRIG: begin
                sub_zera = 1'b1;
                cm_zera  = 1'b1;
                if (trig_s) begin
                    trig_conta = !trig_fim;
                end else begin
                    trig_zera = 1'b1;
                    if (trig_fim) begin
                        aceita = 1'b1;
                        next   = ST_BURST;
                    end else begin
                        next = ST_IDLE;
                    end
                end
            end
            ST_BURST: begin
                trig_zera = 1'b1;
                cm_zera   = 1'b1;
                if (sub_q == SUB_FIM_BURST) begin
                    sub_zera = 1'b1;
                    next     = ST_ECHO;
                end else begin
                    sub_conta = 1'b1;
                end
            end
            ST_ECHO: begin
                trig_zera = 1'b1;
                if (in_range_q) begin
                    if (sub_q == SUB_FIM_CM) begin
                        sub_zera = 1'b1;
                        if (cm_ultimo) begin
                            fim_echo = 1'b1;
                        end else begin
                            cm_conta = 1'b1;
                        end
                    end else begin
                        sub_conta = 1'b1;
                    end
                end else begin
                    if (sub_q == SUB_FIM_TIMEOUT) begin
                        sub_zera = 1'b1;
                        fim_echo = 1'b1;
                    end else begin
                        sub_conta = 1'b1;
                    end
                end
                if (fim_echo) begin
                    cm_zera = 1'b1;
                    next    = ST_POS_ECHO;
                end
            end
`ifdef HCSR04_EMU_HOLDOFF_EN
            ST_HOLDOFF: begin
                trig_zera = 1'b1;
                sub_zera  = 1'b1;
                cm_zera   = 1'b1;
                if (hold_fim) begin
                    next = ST_IDLE;
                end else begin
                    hold_conta = 1'b1;
                end
            end
`endif
            default: begin
                trig_zera = 1'b1;
                sub_zera  = 1'b1;
                cm_zera   = 1'b1;
                next      = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        db_estado = DB_ILEGAL;
        case (state)
            ST_IDLE, ST_TRIG, ST_BURST, ST_ECHO: db_estado = state;
`ifdef HCSR04_EMU_HOLDOFF_EN
            ST_HOLDOFF:                          db_estado = state;
`endif
            default:                             db_estado = DB_ILEGAL;
        endcase
    end

endmodule

// File: tb/tb_hcsr04_sensor_emulator.sv
// -----------------------------------------------------------------------------
// tb_hcsr04_sensor_emulator
// Self-checking bench for hcsr04_sensor_emulator with small timing parameters.
// An interval model (acceptance edge + burst + echo length) predicts echo,
// ocupado and db_estado every cycle; directed tests add literal expectations.
// -----------------------------------------------------------------------------
module tb_hcsr04_sensor_emulator;

    localparam int CPC  = 4;
    localparam int TMIN = 5;
    localparam int BUR  = 10;
    localparam int DMAX = 20;
    localparam int TOUT = 100;
    localparam int HOLD = 30;
`ifdef HCSR04_EMU_HOLDOFF_EN
    localparam int HX = HOLD;
`else
    localparam int HX = 0;
`endif
    localparam int ESPERA = 100;

    logic       clock = 1'b0;
    logic       reset;
    logic       trigger;
    logic [8:0] distancia;
    logic       echo;
    logic       ocupado;
    logic [3:0] db_estado;

    always #5 clock = ~clock;

    hcsr04_sensor_emulator #(
        .CICLOS_POR_CM   (CPC),
        .TRIG_MIN_CICLOS (TMIN),
        .BURST_CICLOS    (BUR),
        .DIST_MAX        (DMAX),
        .TIMEOUT_CICLOS  (TOUT),
        .HOLDOFF_CICLOS  (HOLD)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .trigger   (trigger),
        .distancia (distancia),
        .echo      (echo),
        .ocupado   (ocupado),
        .db_estado (db_estado)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nome, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int cyc    = 0;
    bit m_rst  = 1'b1;
    bit m_s1   = 1'b0;
    bit m_s2   = 1'b0;
    bit m_trig = 1'b0;
    int run    = 0;
    bit a_ok   = 1'b0;
    int a_edge = 0;
    int a_n    = 0;

    function automatic int echo_len(input int d);
        return (d >= 1 && d <= DMAX) ? d * CPC : TOUT;
    endfunction

    function automatic bit busy(input int e);
        return a_ok && (e >= a_edge) && (e < a_edge + BUR + a_n + HX);
    endfunction

    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            m_rst = 1'b1; m_s1 = 1'b0; m_s2 = 1'b0; m_trig = 1'b0; run = 0; a_ok = 1'b0;
        end else begin
            m_rst  = 1'b0;
            m_trig = 1'b0;
            if (!busy(cyc - 1)) begin
                if (m_s2) begin
                    run++;
                    m_trig = 1'b1;
                end else begin
                    if (run >= TMIN) begin
                        a_ok = 1'b1; a_edge = cyc; a_n = echo_len(int'(distancia));
                    end
                    run = 0;
                end
            end else begin
                run = 0;
            end
            m_s2 = m_s1;
            m_s1 = trigger;
        end
    end

    // ---------------- per-cycle compare + echo monitor ----------------
    logic echo_prev = 1'b0;
    int   rise_e = -1, width = 0, cur_w = 0, n_pulses = 0;

    always @(negedge clock) begin
        logic       x_echo, x_ocu;
        logic [3:0] x_db;
        if (cyc > 0) begin
            x_echo = a_ok && !m_rst && (cyc >= a_edge + BUR) && (cyc < a_edge + BUR + a_n);
            x_ocu  = !m_rst && busy(cyc);
            if (m_rst)                      x_db = 4'd0;
            else if (!busy(cyc))            x_db = m_trig ? 4'd1 : 4'd0;
            else if (cyc < a_edge + BUR)    x_db = 4'd2;
            else if (cyc < a_edge + BUR + a_n) x_db = 4'd3;
            else                            x_db = 4'd4;
            check("cyc_echo", echo, x_echo);
            check("cyc_ocupado", ocupado, x_ocu);
            check("cyc_db_estado", db_estado, x_db);
            if (echo === 1'b1 && echo_prev === 1'b0) begin
                rise_e = cyc; cur_w = 0; n_pulses++;
            end
            if (echo === 1'b1) cur_w++;
            if (echo === 1'b0 && echo_prev === 1'b1) width = cur_w;
            echo_prev = echo;
        end
    end

    // ---------------- stimulus ----------------
    task automatic ciclos(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulso(input int d, input int alto);
        distancia = 9'(d);
        trigger   = 1'b1;
        ciclos(alto);
        trigger   = 1'b0;
    endtask

    task automatic espera_queda(input int limite);
        int k;
        k = 0;
        while (echo !== 1'b1 && k < limite) begin ciclos(1); k++; end
        while (echo !== 1'b0 && k < limite) begin ciclos(1); k++; end
        check("echo_fall_in_time", 32'(k < limite), 1);
    endtask

    int p;
    int t3_d[3] = '{0, 25, 20};
    int t3_w[3] = '{100, 100, 80};

    initial begin
        reset = 1'b1; trigger = 1'b0; distancia = 9'd0;
        ciclos(3);
        check("reset_echo", echo, 0);
        check("reset_ocupado", ocupado, 0);
        check("reset_db", db_estado, 0);
        reset = 1'b0;
        ciclos(2);

        // 1: d=7, 6-cycle trigger
        p = n_pulses;
        pulso(7, 6);
        ciclos(ESPERA);
        check("t1_pulses", n_pulses - p, 1);
        check("t1_latency", rise_e - a_edge, 10);
        check("t1_width", width, 28);

        // 2: short trigger rejected
        p = n_pulses;
        pulso(7, 3);
        ciclos(20);
        check("t2_pulses", n_pulses - p, 0);
        check("t2_ocupado", ocupado, 0);
        check("t2_db", db_estado, 0);

        // 3: out-of-range and boundary distances
        for (int i = 0; i < 3; i++) begin
            p = n_pulses;
            pulso(t3_d[i], 6);
            ciclos(TOUT + ESPERA);
            check($sformatf("t3_width_d%0d", t3_d[i]), width, t3_w[i]);
            check("t3_pulses", n_pulses - p, 1);
        end

        // 4: distance change in BURST and retrigger in ECHO ignored
        p = n_pulses;
        pulso(5, 6);
        ciclos(5);
        distancia = 9'd9;
        ciclos(10);
        pulso(9, 6);
        ciclos(ESPERA);
        check("t4_pulses", n_pulses - p, 1);
        check("t4_width", width, 20);

        // 5: reset mid-ECHO, then a fresh transaction
        pulso(7, 6);
        ciclos(18);
        reset = 1'b1;
        ciclos(1);
        check("t5_echo", echo, 0);
        check("t5_ocupado", ocupado, 0);
        check("t5_db", db_estado, 0);
        reset = 1'b0;
        ciclos(1);
        p = n_pulses;
        pulso(3, 6);
        ciclos(ESPERA);
        check("t5_pulses", n_pulses - p, 1);
        check("t5_latency", rise_e - a_edge, 10);
        check("t5_width", width, 12);

        // 7: trigger held high stays in TRIG, accepted on fall
        p = n_pulses;
        distancia = 9'd2;
        trigger = 1'b1;
        ciclos(15);
        check("t7_db_trig", db_estado, 1);
        ciclos(5);
        trigger = 1'b0;
        ciclos(ESPERA);
        check("t7_pulses", n_pulses - p, 1);
        check("t7_width", width, 8);

        // 6: trigger right after echo fall
        pulso(4, 6);
        espera_queda(200);
`ifdef HCSR04_EMU_HOLDOFF_EN
        ciclos(9);
        p = n_pulses;
        pulso(6, 6);
        ciclos(40);
        check("t6_holdoff_ignored", n_pulses - p, 0);
        p = n_pulses;
        pulso(6, 6);
        ciclos(ESPERA);
        check("t6_after_holdoff", n_pulses - p, 1);
        check("t6_width", width, 24);
`else
        p = n_pulses;
        pulso(6, 6);
        ciclos(ESPERA);
        check("t6_back_to_back", n_pulses - p, 1);
        check("t6_width", width, 24);
`endif

        ciclos(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
